// File: rtl/deteccion_frecuencia.sv
// deteccion_frecuencia: measures the half-period of a divided clock and decodes its 3-bit frequency code
module deteccion_frecuencia #(
    parameter int HALF_BASE = 8,
    parameter int TOL       = 1,
    parameter int MATCH_N   = 3,
    parameter int TIMEOUT   = 160
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic       Sig_In,
    output logic [2:0] Frec_Detectada,
    output logic       Valido,
    output logic       Error,
    output logic [7:0] Periodo
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] MEASURE = 2'd1;
    localparam logic [1:0] LOCKED  = 2'd2;

    logic       s1_q, s2_q, s3_q;
    logic       edge_p;
    logic [1:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] cand_q, cand_d;
    logic [3:0] mcnt_q, mcnt_d;
    logic [3:0] nxt_m;
    logic [2:0] frec_q, frec_d;
    logic       val_q, val_d;
    logic       err_q, err_d;
    logic [7:0] per_q, per_d;
    logic       hit;
    logic [2:0] code;

    assign edge_p = s2_q ^ s3_q;

    // decode the current count against every code window; windows never overlap
    always_comb begin
        hit  = 1'b0;
        code = 3'd0;
        for (int k = 0; k < 8; k++)
            if (int'(cnt_q) >= HALF_BASE*(k+1)-TOL && int'(cnt_q) <= HALF_BASE*(k+1)+TOL) begin
                hit  = 1'b1;
                code = 3'(k);
            end
    end

    // measurement state machine: count between edges, track candidate, lock after MATCH_N matches
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        mcnt_d  = mcnt_q;
        frec_d  = frec_q;
        val_d   = val_q;
        err_d   = err_q;
        per_d   = per_q;
        nxt_m   = (code == cand_q) ? mcnt_q + 4'd1 : 4'd1;
        if (state_q == IDLE) begin
            if (edge_p) begin
                cnt_d   = 8'd1;
                state_d = MEASURE;
            end
        end else if (edge_p) begin
            cnt_d = 8'd1;
            per_d = cnt_q;
            if (!hit) begin
                mcnt_d  = 4'd0;
                err_d   = 1'b1;
                val_d   = 1'b0;
                state_d = MEASURE;
            end else begin
                err_d = 1'b0;
                if (state_q == LOCKED && code != cand_q) begin
                    val_d   = 1'b0;
                    cand_d  = code;
                    mcnt_d  = 4'd1;
                    state_d = MEASURE;
                end else if (state_q == MEASURE) begin
                    cand_d = code;
                    mcnt_d = nxt_m;
                    if (nxt_m == 4'(MATCH_N)) begin
                        frec_d  = code;
                        val_d   = 1'b1;
                        state_d = LOCKED;
                    end
                end
            end
        end else if (cnt_q == 8'(TIMEOUT)) begin
            val_d   = 1'b0;
            err_d   = 1'b1;
            mcnt_d  = 4'd0;
            cnt_d   = 8'd0;
            state_d = IDLE;
        end else begin
            cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        end
    end

    // synchronizer, edge-detect flop and all state registers
    always_ff @(posedge CLK) begin
        if (Reset) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            cand_q  <= 3'd0;
            mcnt_q  <= 4'd0;
            frec_q  <= 3'd0;
            val_q   <= 1'b0;
            err_q   <= 1'b0;
            per_q   <= 8'd0;
        end else begin
            s1_q    <= Sig_In;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
            mcnt_q  <= mcnt_d;
            frec_q  <= frec_d;
            val_q   <= val_d;
            err_q   <= err_d;
            per_q   <= per_d;
        end
    end

    assign Frec_Detectada = frec_q;
    assign Valido         = val_q;
    assign Error          = err_q;
    assign Periodo        = per_q;
endmodule

// File: tb/tb_deteccion_frecuencia.sv
// tb_deteccion_frecuencia: randomized and directed checks against an event-level reference model
module tb_deteccion_frecuencia;
    localparam int HB  = 8;
    localparam int TOL = 1;
    localparam int MN  = 3;
    localparam int TO  = 160;

    logic       CLK = 1'b0;
    logic       Reset = 1'b1;
    logic       Sig_In = 1'b0;
    logic [2:0] Frec_Detectada;
    logic       Valido;
    logic       Error;
    logic [7:0] Periodo;
    logic [12:0] obs;

    int ntests = 0;
    int nfail  = 0;
    int since  = 0;

    // reference model, advanced once per input transition
    int m_active, m_locked, m_cand, m_cnt, m_frec, m_val, m_err, m_per;

    deteccion_frecuencia dut (
        .CLK(CLK), .Reset(Reset), .Sig_In(Sig_In),
        .Frec_Detectada(Frec_Detectada), .Valido(Valido), .Error(Error), .Periodo(Periodo)
    );

    always #5 CLK = ~CLK;

    assign obs = {Frec_Detectada, Valido, Error, Periodo};

    function automatic logic [12:0] expv();
        return {3'(m_frec), 1'(m_val), 1'(m_err), 8'(m_per)};
    endfunction

    task automatic model_reset();
        m_active = 0; m_locked = 0; m_cand = 0; m_cnt = 0;
        m_frec = 0; m_val = 0; m_err = 0; m_per = 0;
    endtask

    task automatic model_edge(input int h);
        int kk, c;
        bit ok;
        if (m_active != 0 && h > TO) begin
            m_val = 0; m_err = 1; m_cnt = 0; m_active = 0; m_locked = 0;
        end
        if (m_active == 0) begin
            m_active = 1;
            return;
        end
        m_per = (h > 255) ? 255 : h;
        kk = (h + TOL) / HB;
        ok = (kk >= 1) && (kk <= 8) && (h <= HB*kk + TOL);
        c  = kk - 1;
        if (!ok) begin
            m_cnt = 0; m_err = 1; m_val = 0; m_locked = 0;
        end else begin
            m_err = 0;
            if (m_locked != 0) begin
                if (c != m_cand) begin
                    m_val = 0; m_cand = c; m_cnt = 1; m_locked = 0;
                end
            end else begin
                m_cnt  = (c == m_cand) ? m_cnt + 1 : 1;
                m_cand = c;
                if (m_cnt == MN) begin
                    m_frec = c; m_val = 1; m_locked = 1;
                end
            end
        end
    endtask

    task automatic apply_reset();
        Reset = 1'b1;
        Sig_In = 1'b0;
        @(posedge CLK); #1;
        Reset = 1'b0;
        model_reset();
        since = 0;
    endtask

    // toggle Sig_In h cycles after the previous toggle, then let 3 cycles of latency elapse
    task automatic do_half(input int h);
        repeat (h - since) @(posedge CLK);
        #1;
        Sig_In = ~Sig_In;
        model_edge(h);
        since = 0;
        repeat (3) @(posedge CLK);
        #1;
        since = 3;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        ntests++; if (obs !== 13'h0) begin nfail++; $display("FAIL reset_outputs obs=%h exp=0", obs); end
        apply_reset();
        repeat (200) @(posedge CLK);
        #1;
        ntests++; if (obs !== 13'h0) begin nfail++; $display("FAIL idle_constant obs=%h exp=0", obs); end
    endtask

    task automatic test_basic();
        for (int i = 0; i < 3; i++) begin
            do_half(8);
            ntests++; if (obs !== expv() || Valido !== 1'b0) begin nfail++; $display("FAIL basic_pre%0d obs=%h exp=%h", i, obs, expv()); end
        end
        repeat (8 - since) @(posedge CLK);
        #1;
        Sig_In = ~Sig_In;
        model_edge(8);
        repeat (2) @(posedge CLK);
        #1;
        ntests++; if (Valido !== 1'b0) begin nfail++; $display("FAIL basic_early valido=%b exp=0", Valido); end
        @(posedge CLK);
        #1;
        since = 3;
        ntests++; if (obs !== {3'd0, 1'b1, 1'b0, 8'd8}) begin nfail++; $display("FAIL basic_lock obs=%h exp=%h", obs, {3'd0, 1'b1, 1'b0, 8'd8}); end
    endtask

    task automatic test_codes();
        apply_reset();
        for (int i = 0; i < 4; i++) do_half(64);
        ntests++; if (obs !== {3'd7, 1'b1, 1'b0, 8'd64}) begin nfail++; $display("FAIL code7 obs=%h exp=%h", obs, {3'd7, 1'b1, 1'b0, 8'd64}); end
        apply_reset();
        for (int i = 0; i < 4; i++) do_half(7);
        ntests++; if (obs !== {3'd0, 1'b1, 1'b0, 8'd7}) begin nfail++; $display("FAIL tol_low obs=%h exp=%h", obs, {3'd0, 1'b1, 1'b0, 8'd7}); end
        apply_reset();
        for (int i = 0; i < 4; i++) do_half(9);
        ntests++; if (obs !== {3'd0, 1'b1, 1'b0, 8'd9}) begin nfail++; $display("FAIL tol_high obs=%h exp=%h", obs, {3'd0, 1'b1, 1'b0, 8'd9}); end
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            do_half(10);
            ntests++; if (Valido !== 1'b0 || obs !== expv()) begin nfail++; $display("FAIL miss10_%0d obs=%h exp=%h", i, obs, expv()); end
        end
        ntests++; if (Error !== 1'b1) begin nfail++; $display("FAIL miss10_err error=%b exp=1", Error); end
    endtask

    task automatic test_switch();
        apply_reset();
        for (int i = 0; i < 4; i++) do_half(24);
        ntests++; if (obs !== {3'd2, 1'b1, 1'b0, 8'd24}) begin nfail++; $display("FAIL sw_lock2 obs=%h exp=%h", obs, {3'd2, 1'b1, 1'b0, 8'd24}); end
        for (int i = 0; i < 3; i++) begin
            do_half(48);
            ntests++; if (obs !== expv()) begin nfail++; $display("FAIL sw_step%0d obs=%h exp=%h", i, obs, expv()); end
            if (i < 2) begin
                ntests++; if (Frec_Detectada !== 3'd2 || Valido !== 1'b0) begin nfail++; $display("FAIL sw_hold%0d frec=%0d val=%b exp=2,0", i, Frec_Detectada, Valido); end
            end
        end
        ntests++; if (obs !== {3'd5, 1'b1, 1'b0, 8'd48}) begin nfail++; $display("FAIL sw_lock5 obs=%h exp=%h", obs, {3'd5, 1'b1, 1'b0, 8'd48}); end
    endtask

    task automatic test_stall();
        apply_reset();
        for (int i = 0; i < 4; i++) do_half(32);
        repeat (159) @(posedge CLK);
        #1;
        ntests++; if (Valido !== 1'b1) begin nfail++; $display("FAIL stall_early valido=%b exp=1", Valido); end
        @(posedge CLK);
        #1;
        since = 163;
        ntests++; if (obs !== {3'd3, 1'b0, 1'b1, 8'd32}) begin nfail++; $display("FAIL stall_timeout obs=%h exp=%h", obs, {3'd3, 1'b0, 1'b1, 8'd32}); end
        do_half(200);
        ntests++; if (obs !== expv() || Error !== 1'b1) begin nfail++; $display("FAIL stall_start obs=%h exp=%h", obs, expv()); end
        do_half(32);
        ntests++; if (obs !== expv() || Error !== 1'b0) begin nfail++; $display("FAIL stall_errclr obs=%h exp=%h", obs, expv()); end
        do_half(32);
        do_half(32);
        ntests++; if (obs !== {3'd3, 1'b1, 1'b0, 8'd32}) begin nfail++; $display("FAIL stall_relock obs=%h exp=%h", obs, {3'd3, 1'b1, 1'b0, 8'd32}); end
    endtask

    task automatic test_timeout_boundary();
        apply_reset();
        for (int i = 0; i < 4; i++) do_half(64);
        do_half(TO);
        ntests++; if (obs !== {3'd7, 1'b0, 1'b1, 8'(TO)}) begin nfail++; $display("FAIL to_coincident obs=%h exp=%h", obs, {3'd7, 1'b0, 1'b1, 8'(TO)}); end
        do_half(8);
        ntests++; if (obs !== expv() || Periodo !== 8'd8) begin nfail++; $display("FAIL to_after_edge obs=%h exp=%h", obs, expv()); end
        do_half(TO + 1);
        ntests++; if (obs !== expv() || Periodo !== 8'd8) begin nfail++; $display("FAIL to_expired obs=%h exp=%h", obs, expv()); end
        do_half(16);
        ntests++; if (obs !== expv() || Periodo !== 8'd16) begin nfail++; $display("FAIL to_restart obs=%h exp=%h", obs, expv()); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        for (int i = 0; i < 4; i++) do_half(56);
        ntests++; if (obs !== {3'd6, 1'b1, 1'b0, 8'd56}) begin nfail++; $display("FAIL rm_lock6 obs=%h exp=%h", obs, {3'd6, 1'b1, 1'b0, 8'd56}); end
        apply_reset();
        ntests++; if (obs !== 13'h0) begin nfail++; $display("FAIL rm_cleared obs=%h exp=0", obs); end
        for (int i = 0; i < 4; i++) begin
            do_half(56);
            ntests++; if (obs !== expv() || Valido !== (i == 3)) begin nfail++; $display("FAIL rm_relock%0d obs=%h exp=%h", i, obs, expv()); end
        end
    endtask

    task automatic test_glitch();
        apply_reset();
        for (int i = 0; i < 4; i++) do_half(16);
        do_half(20);
        ntests++; if (obs !== {3'd1, 1'b0, 1'b1, 8'd20}) begin nfail++; $display("FAIL gl_hit obs=%h exp=%h", obs, {3'd1, 1'b0, 1'b1, 8'd20}); end
        for (int i = 0; i < 3; i++) begin
            do_half(16);
            ntests++; if (obs !== expv() || Valido !== (i == 2)) begin nfail++; $display("FAIL gl_recover%0d obs=%h exp=%h", i, obs, expv()); end
        end
    endtask

    task automatic test_random();
        int k, h, run;
        apply_reset();
        k = 0;
        run = 0;
        for (int i = 0; i < 150; i++) begin
            if (run == 0) begin
                k = $urandom_range(0, 7);
                run = $urandom_range(1, 6);
            end
            run--;
            if ($urandom_range(0, 9) < 8) h = HB*(k+1) + $urandom_range(0, 2*TOL) - TOL;
            else h = $urandom_range(3, 180);
            do_half(h);
            ntests++; if (obs !== expv()) begin nfail++; $display("FAIL rand%0d h=%0d obs=%h exp=%h", i, h, obs, expv()); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_codes();
        test_switch();
        test_stall();
        test_timeout_boundary();
        test_reset_mid();
        test_glitch();
        test_random();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
